// File: rtl/bcd_pkg.sv
// Shared types and helpers for the BCD scan driver and its conversion engine.
package bcd_pkg;

  // Conversion sequencer states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } state_e;

  // Nibble value driven on digito for a blanked position.
  localparam logic [3:0] BCD_BLANK = 4'hF;

  // Width of the digit index; a single digit still needs one bit.
  function automatic int dig_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one bit per clock, MSB first, with
// overflow detection and a display register that only changes on completion.
module bin2bcd_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W   = 8,
  parameter int NUM_DIG = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_i,
  input  logic [BIN_W-1:0]       bin_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   ovf_o,
  output logic [4*NUM_DIG-1:0]   bcd_o
);

  localparam int BCD_W = 4 * NUM_DIG;
  localparam int CNT_W = $clog2(BIN_W + 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_flag_q, ovf_flag_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               ovf_q, ovf_d;
  logic [BCD_W-1:0]   disp_q, disp_d;

  // Working registers carry data only and need no reset.
  logic [BIN_W-1:0]   sh_q, sh_d;
  logic [BCD_W-1:0]   work_q, work_d;
  logic [BCD_W-1:0]   adj;

  // Add 3 to every nibble that is 5 or more, ahead of the left shift.
  function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] v);
    logic [BCD_W-1:0] r;
    r = v;
    for (int i = 0; i < NUM_DIG; i++) begin
      if (v[4*i +: 4] >= 4'd5) r[4*i +: 4] = v[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  // Next-state and output logic of the conversion sequencer.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ovf_flag_d = ovf_flag_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    ovf_d      = ovf_q;
    disp_d     = disp_q;
    sh_d       = sh_q;
    work_d     = work_q;
    adj        = dabble_adjust(work_q);
    unique case (state_q)
      IDLE: begin
        // A request on the done cycle is refused as well as while busy.
        if (start_i && !done_q) begin
          sh_d       = bin_i;
          work_d     = '0;
          ovf_flag_d = 1'b0;
          cnt_d      = '0;
          busy_d     = 1'b1;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        work_d     = {adj[BCD_W-2:0], sh_q[BIN_W-1]};
        sh_d       = {sh_q[BIN_W-2:0], 1'b0};
        ovf_flag_d = ovf_flag_q | adj[BCD_W-1];
        cnt_d      = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(BIN_W - 1)) state_d = FINISH;
      end
      FINISH: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        ovf_d   = ovf_flag_q;
        disp_d  = ovf_flag_q ? {NUM_DIG{4'd9}} : work_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and result registers; reset aborts any conversion in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      ovf_flag_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      disp_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ovf_flag_q <= ovf_flag_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
      disp_q     <= disp_d;
    end
  end

  // Shift datapath registers.
  always_ff @(posedge clk) begin
    sh_q   <= sh_d;
    work_q <= work_d;
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign ovf_o  = ovf_q;
  assign bcd_o  = disp_q;

endmodule

// File: rtl/bcd_scan_driver.sv
// Binary-to-BCD display driver: converts on request and multiplexes the
// resulting digits onto an active-low anode scan with leading-zero blanking.
module bcd_scan_driver
  import bcd_pkg::*;
#(
  parameter int BIN_W    = 8,
  parameter int NUM_DIG  = 3,
  parameter int SCAN_DIV = 10000
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [BIN_W-1:0]                bin,
  input  logic                            load,
  input  logic                            blank_en,
  output logic                            busy,
  output logic                            done,
  output logic                            ovf,
  output logic [3:0]                      digito,
  output logic [NUM_DIG-1:0]              anodo,
  output logic [dig_idx_w(NUM_DIG)-1:0]   dig_idx
);

  localparam int IDX_W = dig_idx_w(NUM_DIG);
  localparam int PRE_W = $clog2(SCAN_DIV);

  logic [4*NUM_DIG-1:0] disp;

  logic [PRE_W-1:0]   pre_q, pre_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [3:0]         digito_q, digito_d;
  logic [NUM_DIG-1:0] anodo_q, anodo_d;
  logic [IDX_W-1:0]   msd;
  logic [3:0]         nib;
  logic               blank;

  bin2bcd_seq #(
    .BIN_W   (BIN_W),
    .NUM_DIG (NUM_DIG)
  ) u_conv (
    .clk     (clk),
    .rst     (rst),
    .start_i (load),
    .bin_i   (bin),
    .busy_o  (busy),
    .done_o  (done),
    .ovf_o   (ovf),
    .bcd_o   (disp)
  );

  // Free-running prescaler; each wrap steps to the next digit position.
  always_comb begin
    pre_d = pre_q + PRE_W'(1);
    idx_d = idx_q;
    if (pre_q == PRE_W'(SCAN_DIV - 1)) begin
      pre_d = '0;
      idx_d = (idx_q == IDX_W'(NUM_DIG - 1)) ? '0 : idx_q + IDX_W'(1);
    end
  end

  // Select the nibble for the upcoming position and decide whether to blank it.
  always_comb begin
    msd = '0;
    nib = 4'd0;
    for (int i = 1; i < NUM_DIG; i++) begin
      if (disp[4*i +: 4] != 4'd0) msd = IDX_W'(i);
    end
    for (int i = 0; i < NUM_DIG; i++) begin
      if (idx_d == IDX_W'(i)) nib = disp[4*i +: 4];
    end
    // Position 0 can never exceed msd, so a zero value still shows "0".
    blank    = blank_en && (idx_d > msd);
    digito_d = blank ? BCD_BLANK : nib;
    for (int i = 0; i < NUM_DIG; i++) begin
      anodo_d[i] = blank || (idx_d != IDX_W'(i));
    end
  end

  // Scan registers: index, digit and anode pattern move on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q    <= '0;
      idx_q    <= '0;
      digito_q <= 4'd0;
      anodo_q  <= {{(NUM_DIG-1){1'b1}}, 1'b0};
    end else begin
      pre_q    <= pre_d;
      idx_q    <= idx_d;
      digito_q <= digito_d;
      anodo_q  <= anodo_d;
    end
  end

  assign digito  = digito_q;
  assign anodo   = anodo_q;
  assign dig_idx = idx_q;

endmodule

// File: tb/tb_bcd_scan_driver.sv
// Bench for bcd_scan_driver: a 3-digit and a 2-digit instance share stimulus;
// expected digits, overflow and blanking come from decimal arithmetic.
module tb_bcd_scan_driver;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load = 1'b0;
  logic       blank_en = 1'b0;
  logic [7:0] bin = 8'd0;

  logic       a_busy, a_done, a_ovf;
  logic [3:0] a_dig;
  logic [2:0] a_an;
  logic [1:0] a_idx;

  logic       b_busy, b_done, b_ovf;
  logic [3:0] b_dig;
  logic [1:0] b_an;
  logic [0:0] b_idx;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  bcd_scan_driver #(.BIN_W(8), .NUM_DIG(3), .SCAN_DIV(4)) dut_a (
    .clk(clk), .rst(rst), .bin(bin), .load(load), .blank_en(blank_en),
    .busy(a_busy), .done(a_done), .ovf(a_ovf),
    .digito(a_dig), .anodo(a_an), .dig_idx(a_idx)
  );

  bcd_scan_driver #(.BIN_W(8), .NUM_DIG(2), .SCAN_DIV(3)) dut_b (
    .clk(clk), .rst(rst), .bin(bin), .load(load), .blank_en(blank_en),
    .busy(b_busy), .done(b_done), .ovf(b_ovf),
    .digito(b_dig), .anodo(b_an), .dig_idx(b_idx)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: decimal digits of the value.
  function automatic int pow10(input int p);
    int r;
    r = 1;
    for (int i = 0; i < p; i++) r = r * 10;
    return r;
  endfunction

  function automatic int exp_ovf(input int v, input int nd);
    return (v > pow10(nd) - 1) ? 1 : 0;
  endfunction

  function automatic int exp_nib(input int v, input int p, input int nd);
    if (exp_ovf(v, nd) != 0) return 9;
    return (v / pow10(p)) % 10;
  endfunction

  // A position is blank when every digit from it upward is zero.
  function automatic int exp_blank(input int v, input int p, input int nd, input int bl);
    if (bl == 0 || p == 0 || exp_ovf(v, nd) != 0) return 0;
    return (v < pow10(p)) ? 1 : 0;
  endfunction

  function automatic int idx_of(input int sel);
    return (sel != 0) ? int'(b_idx) : int'(a_idx);
  endfunction

  function automatic int dig_of(input int sel);
    return (sel != 0) ? int'(b_dig) : int'(a_dig);
  endfunction

  function automatic int an_of(input int sel);
    return (sel != 0) ? int'(b_an) : int'(a_an);
  endfunction

  task automatic check_display(input int sel, input int v, input int bl);
    int nd;
    int ones;
    int k;
    int eb;
    nd   = (sel != 0) ? 2 : 3;
    ones = (1 << nd) - 1;
    for (int p = 0; p < nd; p++) begin
      k = 0;
      while (idx_of(sel) != p && k < 40) begin
        tick();
        k++;
      end
      eb = exp_blank(v, p, nd, bl);
      chk($sformatf("idx_u%0d_v%0d_p%0d", sel, v, p), idx_of(sel), p);
      chk($sformatf("digito_u%0d_v%0d_p%0d", sel, v, p), dig_of(sel),
          (eb != 0) ? 15 : exp_nib(v, p, nd));
      chk($sformatf("anodo_u%0d_v%0d_p%0d", sel, v, p), an_of(sel),
          (eb != 0) ? ones : (ones ^ (1 << p)));
    end
  endtask

  task automatic convert(input int v);
    int k;
    bin  = 8'(v);
    load = 1'b1;
    tick();
    load = 1'b0;
    chk($sformatf("busy_after_load_v%0d", v), a_busy, 1);
    k = 1;
    while (!a_done && k < 40) begin
      tick();
      k++;
    end
    chk($sformatf("latency_v%0d", v), k, 10);
    chk($sformatf("done_b_v%0d", v), b_done, 1);
    chk($sformatf("ovf_a_v%0d", v), a_ovf, exp_ovf(v, 3));
    chk($sformatf("ovf_b_v%0d", v), b_ovf, exp_ovf(v, 2));
    chk($sformatf("busy_on_done_v%0d", v), a_busy, 0);
    tick();
    chk($sformatf("done_single_v%0d", v), a_done, 0);
  endtask

  initial begin
    int v;
    int bl;
    int nd;

    // Reset state.
    rst = 1'b1;
    tick();
    tick();
    chk("rst_busy", a_busy, 0);
    chk("rst_done", a_done, 0);
    chk("rst_ovf", a_ovf, 0);
    chk("rst_digito", a_dig, 0);
    chk("rst_idx", a_idx, 0);
    chk("rst_anodo", a_an, 3'b110);
    chk("rst_anodo_b", b_an, 2'b10);

    // Scan sequence straight out of reset: 0,1,2,0 each for four cycles.
    tick();
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("scan_idx_%0d", i), a_idx, (i / 4) % 3);
      chk($sformatf("scan_an_%0d", i), a_an, 3'b111 ^ (3'b001 << ((i / 4) % 3)));
      tick();
    end

    // Directed conversions.
    blank_en = 1'b0;
    convert(157);
    check_display(0, 157, 0);
    check_display(1, 157, 0);
    convert(255);
    check_display(0, 255, 0);
    check_display(1, 255, 0);
    blank_en = 1'b1;
    convert(7);
    check_display(0, 7, 1);
    check_display(1, 7, 1);
    convert(0);
    check_display(0, 0, 1);
    check_display(1, 0, 1);

    // Randomized values and blanking.
    for (int r = 0; r < 10; r++) begin
      v  = int'($urandom_range(0, 255));
      bl = int'($urandom_range(0, 1));
      blank_en = bl[0];
      convert(v);
      check_display(0, v, bl);
      check_display(1, v, bl);
    end

    // Loads while busy and on the done cycle are dropped.
    blank_en = 1'b0;
    bin  = 8'd42;
    load = 1'b1;
    tick();
    bin = 8'd99;
    tick();
    load = 1'b0;
    nd = 0;
    for (int k = 0; k < 30; k++) begin
      if (a_done) begin
        nd++;
        load = 1'b1;
        bin  = 8'd200;
      end else begin
        load = 1'b0;
      end
      tick();
    end
    load = 1'b0;
    chk("one_done_pulse", nd, 1);
    chk("idle_after_ignored", a_busy, 0);
    check_display(0, 42, 0);

    // Reset in the fourth shift cycle aborts the conversion.
    convert(123);
    check_display(0, 123, 0);
    bin  = 8'd200;
    load = 1'b1;
    tick();
    load = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", a_busy, 0);
    chk("abort_done", a_done, 0);
    chk("abort_ovf", a_ovf, 0);
    chk("abort_digito", a_dig, 0);
    chk("abort_idx", a_idx, 0);
    chk("abort_anodo", a_an, 3'b110);
    nd = 0;
    for (int k = 0; k < 20; k++) begin
      if (a_done) nd++;
      tick();
    end
    chk("abort_no_done", nd, 0);
    check_display(0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
